// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: command codes, FSM states,
// response constants and err_flags bit positions.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_CSR_WR   = 8'h00;
    localparam logic [7:0] CMD_CSR_RD   = 8'h10;
    localparam logic [7:0] CMD_BUF_WR_A = 8'h20;
    localparam logic [7:0] CMD_BUF_WR_B = 8'h30;
    localparam logic [7:0] CMD_START    = 8'h50;
    localparam logic [7:0] CMD_STATUS   = 8'h70;

    localparam int PKT_BYTES = 7;

    localparam logic [7:0]  ACK_OK  = 8'hA5;
    localparam logic [7:0]  ACK_ERR = 8'hEE;
    localparam logic [31:0] BAD_RD  = 32'hDEADBEEF;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_OVERRUN = 2;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        EXEC,
        RD_WAIT,
        TX
    } state_t;

endpackage

// File: rtl/uart_cmd_resp_ser.sv
// Serializes a 1..4 byte response word LSB-first onto a valid/ready byte stream;
// done pulses combinationally with the handshake of the final byte.
module uart_cmd_resp_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [2:0]  nbytes,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] shreg;
    logic [2:0]  remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            remaining <= '0;
        end else if (load) begin
            shreg     <= word;
            remaining <= nbytes;
        end else if (tx_valid && tx_ready) begin
            shreg     <= shreg >> 8;
            remaining <= remaining - 3'd1;
        end
    end

    assign tx_valid = (remaining != 3'd0);
    assign tx_data  = tx_valid ? shreg[7:0] : 8'h00;
    assign done     = tx_valid && tx_ready && (remaining == 3'd1);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer: assembles 7-byte UART packets and dispatches CSR, buffer,
// START and STATUS operations. Define UART_CMD_ACK_EN to acknowledge write-type packets.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int BUF_AW       = 6,
    parameter int CSR_AW       = 8,
    parameter int BYTE_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              csr_wr_en,
    output logic              csr_rd_en,
    output logic [CSR_AW-1:0] csr_addr,
    output logic [31:0]       csr_wdata,
    input  logic [31:0]       csr_rdata,
    output logic              a_wr_en,
    output logic              b_wr_en,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [31:0]       buf_wdata,
    output logic              start_pulse,
    input  logic              core_busy,
    input  logic              core_done,
    output logic [2:0]        err_flags
);

    localparam int TW = $clog2(BYTE_TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [2:0]    byte_cnt;
    logic [7:0]    cmd;
    logic [15:0]   addr;
    logic [31:0]   data;
    logic [TW-1:0] tmo_cnt;
    logic          done_sticky;

    logic        csr_bad, buf_bad, tmo_hit, overrun_hit;
    logic        exec_illegal, start_ok, status_clr;
    logic [2:0]  err_set;
    logic        ser_load, ser_done;
    logic [31:0] ser_word;
    logic [2:0]  ser_nbytes;

    assign csr_addr  = addr[CSR_AW-1:0];
    assign buf_addr  = addr[BUF_AW-1:0];
    assign csr_wdata = data;
    assign buf_wdata = data;

    always_comb begin
        csr_bad     = (addr >> CSR_AW) != '0;
        buf_bad     = (addr >> BUF_AW) != '0;
        tmo_hit     = (state == COLLECT) && !rx_valid && (tmo_cnt == TW'(BYTE_TIMEOUT - 1));
        overrun_hit = rx_valid && (state == EXEC || state == RD_WAIT || state == TX);
    end

    always_comb begin
        state_nxt    = state;
        csr_wr_en    = 1'b0;
        csr_rd_en    = 1'b0;
        a_wr_en      = 1'b0;
        b_wr_en      = 1'b0;
        start_pulse  = 1'b0;
        exec_illegal = 1'b0;
        start_ok     = 1'b0;
        status_clr   = 1'b0;
        ser_load     = 1'b0;
        ser_word     = '0;
        ser_nbytes   = '0;
        case (state)
            IDLE: begin
                if (rx_valid) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (rx_valid && byte_cnt == 3'(PKT_BYTES - 1)) state_nxt = EXEC;
                else if (tmo_hit)                              state_nxt = IDLE;
            end
            EXEC: begin
                state_nxt = IDLE;
                case (cmd)
                    CMD_CSR_WR: begin
                        exec_illegal = csr_bad;
                        csr_wr_en    = !csr_bad;
                    end
                    CMD_CSR_RD: begin
                        exec_illegal = csr_bad;
                        csr_rd_en    = !csr_bad;
                        state_nxt    = RD_WAIT;
                    end
                    CMD_BUF_WR_A: begin
                        exec_illegal = buf_bad;
                        a_wr_en      = !buf_bad;
                    end
                    CMD_BUF_WR_B: begin
                        exec_illegal = buf_bad;
                        b_wr_en      = !buf_bad;
                    end
                    CMD_START: begin
                        exec_illegal = core_busy;
                        start_ok     = !core_busy;
                        start_pulse  = !core_busy;
                    end
                    CMD_STATUS: begin
                        // Snapshot reflects flags before this cycle's clear and sets
                        status_clr = 1'b1;
                        ser_load   = 1'b1;
                        ser_word   = {26'b0, err_flags, done_sticky, core_busy};
                        ser_nbytes = 3'd4;
                        state_nxt  = TX;
                    end
                    default: exec_illegal = 1'b1;
                endcase
`ifdef UART_CMD_ACK_EN
                if (cmd != CMD_CSR_RD && cmd != CMD_STATUS) begin
                    ser_load   = 1'b1;
                    ser_word   = {24'b0, (exec_illegal ? ACK_ERR : ACK_OK)};
                    ser_nbytes = 3'd1;
                    state_nxt  = TX;
                end
`endif
            end
            RD_WAIT: begin
                ser_load   = 1'b1;
                ser_word   = csr_bad ? BAD_RD : csr_rdata;
                ser_nbytes = 3'd4;
                state_nxt  = TX;
            end
            TX: begin
                if (ser_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            cmd      <= '0;
            addr     <= '0;
            data     <= '0;
            tmo_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == COLLECT && !rx_valid) tmo_cnt <= tmo_cnt + TW'(1);
            else                               tmo_cnt <= '0;
            if (rx_valid && state == IDLE) begin
                cmd      <= rx_data;
                byte_cnt <= 3'd1;
            end else if (rx_valid && state == COLLECT) begin
                // Bytes arrive LSB-first, so shift each new byte in from the top
                byte_cnt <= byte_cnt + 3'd1;
                if (byte_cnt < 3'd3) addr <= {rx_data, addr[15:8]};
                else                 data <= {rx_data, data[31:8]};
            end
        end
    end

    always_comb begin
        err_set              = '0;
        err_set[ERR_ILLEGAL] = exec_illegal;
        err_set[ERR_TIMEOUT] = tmo_hit;
        err_set[ERR_OVERRUN] = overrun_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags   <= '0;
            done_sticky <= 1'b0;
        end else begin
            err_flags   <= (status_clr ? 3'b000 : err_flags) | err_set;
            done_sticky <= core_done | (done_sticky & !start_ok);
        end
    end

    uart_cmd_resp_ser u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .word     (ser_word),
        .nbytes   (ser_nbytes),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl in its default build (no command ACK).
module tb_uart_cmd_ctrl;

    localparam int BUF_AW       = 6;
    localparam int CSR_AW       = 8;
    localparam int BYTE_TIMEOUT = 50000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              csr_wr_en, csr_rd_en;
    logic [CSR_AW-1:0] csr_addr;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata = '0;
    logic              a_wr_en, b_wr_en;
    logic [BUF_AW-1:0] buf_addr;
    logic [31:0]       buf_wdata;
    logic              start_pulse;
    logic              core_busy = 1'b0;
    logic              core_done = 1'b0;
    logic [2:0]        err_flags;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, rd_cnt = 0, a_cnt = 0, b_cnt = 0, st_cnt = 0, tx_cyc = 0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.BUF_AW(BUF_AW), .CSR_AW(CSR_AW), .BYTE_TIMEOUT(BYTE_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .a_wr_en(a_wr_en), .b_wr_en(b_wr_en),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .start_pulse(start_pulse),
        .core_busy(core_busy), .core_done(core_done), .err_flags(err_flags)
    );

    always @(posedge clk) begin
        if (csr_wr_en)   wr_cnt++;
        if (csr_rd_en)   rd_cnt++;
        if (a_wr_en)     a_cnt++;
        if (b_wr_en)     b_cnt++;
        if (start_pulse) st_cnt++;
        if (tx_valid)    tx_cyc++;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d);
        send_byte(c);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic recv_word(input int n, input bit toggle, input bit inject,
                             output logic [31:0] w, output int got);
        w   = '0;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < n; cyc++) begin
            tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            rx_data  = 8'h55;
            rx_valid = inject && (cyc == 3);
            if (tx_valid && tx_ready) begin
                w[8*got +: 8] = tx_data;
                got++;
            end
            step(1);
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic do_status(output logic [31:0] w, output int got);
        send_pkt(8'h70, 16'h0000, 32'h0);
        recv_word(4, 1'b0, 1'b0, w, got);
    endtask

    task automatic test_reset;
        checks++;
        if ({csr_wr_en, csr_rd_en, a_wr_en, b_wr_en, start_pulse, tx_valid} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes got=%b exp=000000",
                     {csr_wr_en, csr_rd_en, a_wr_en, b_wr_en, start_pulse, tx_valid});
        end
        checks++;
        if (err_flags !== 3'b000 || tx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b/%h exp=000/00", err_flags, tx_data);
        end
        checks++;
        if (csr_addr !== 8'h00 || csr_wdata !== 32'h0 || buf_addr !== 6'h00) begin
            errors++;
            $display("[TB] FAIL reset_addr got=%h/%h/%h exp=0/0/0", csr_addr, csr_wdata, buf_addr);
        end
    endtask

    task automatic test_csr_wr;
        int w0 = wr_cnt;
        int t0 = tx_cyc;
        send_pkt(8'h00, 16'h0008, 32'h0000_0008);
        checks++;
        if (csr_wr_en !== 1'b1 || csr_addr !== 8'h08 || csr_wdata !== 32'h8) begin
            errors++;
            $display("[TB] FAIL csr_wr_exec got=%b/%h/%h exp=1/08/00000008", csr_wr_en, csr_addr, csr_wdata);
        end
        step(1);
        checks++;
        if (csr_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csr_wr_one_cycle got=%b exp=0", csr_wr_en);
        end
        step(3);
        checks++;
        if (wr_cnt - w0 != 1 || tx_cyc != t0 || err_flags !== 3'b000) begin
            errors++;
            $display("[TB] FAIL csr_wr_after got=%0d/%0d/%b exp=1/0/000", wr_cnt - w0, tx_cyc - t0, err_flags);
        end
    endtask

    task automatic test_buf_wr;
        logic [31:0] w;
        int got;
        int b0 = b_cnt;
        send_pkt(8'h30, 16'h0001, 32'h0C0B_0A09);
        checks++;
        if (b_wr_en !== 1'b1 || a_wr_en !== 1'b0 || buf_addr !== 6'd1 || buf_wdata !== 32'h0C0B_0A09) begin
            errors++;
            $display("[TB] FAIL buf_wr_b got=%b%b/%h/%h exp=10/01/0c0b0a09", b_wr_en, a_wr_en, buf_addr, buf_wdata);
        end
        step(1);
        send_pkt(8'h20, 16'h0005, 32'hCAFE_F00D);
        checks++;
        if (a_wr_en !== 1'b1 || b_wr_en !== 1'b0 || buf_addr !== 6'd5 || buf_wdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("[TB] FAIL buf_wr_a got=%b%b/%h/%h exp=10/05/cafef00d", a_wr_en, b_wr_en, buf_addr, buf_wdata);
        end
        step(1);
        send_pkt(8'h30, 16'h0040, 32'h1122_3344);
        checks++;
        if (b_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL buf_wr_bad_addr got=%b exp=0", b_wr_en);
        end
        step(1);
        checks++;
        if (b_cnt - b0 != 1 || err_flags !== 3'b001) begin
            errors++;
            $display("[TB] FAIL buf_wr_illegal got=%0d/%b exp=1/001", b_cnt - b0, err_flags);
        end
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0004) begin
            errors++;
            $display("[TB] FAIL status_illegal got=%h/%0d exp=00000004/4", w, got);
        end
        checks++;
        if (err_flags !== 3'b000) begin
            errors++;
            $display("[TB] FAIL status_clear got=%b exp=000", err_flags);
        end
    endtask

    task automatic test_start_done;
        logic [31:0] w;
        int got;
        int s0 = st_cnt;
        send_pkt(8'h50, 16'h0000, 32'h0);
        checks++;
        if (start_pulse !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_pulse got=%b exp=1", start_pulse);
        end
        step(1);
        core_busy = 1'b1;
        step(5);
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
        core_busy = 1'b0;
        step(2);
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0002) begin
            errors++;
            $display("[TB] FAIL status_done got=%h/%0d exp=00000002/4", w, got);
        end
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0002 || st_cnt - s0 != 1) begin
            errors++;
            $display("[TB] FAIL status_done_sticky got=%h/%0d exp=00000002/1", w, st_cnt - s0);
        end
    endtask

    task automatic test_start_busy;
        logic [31:0] w;
        int got;
        int s0 = st_cnt;
        core_busy = 1'b1;
        send_pkt(8'h50, 16'h0000, 32'h0);
        checks++;
        if (start_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_busy_pulse got=%b exp=0", start_pulse);
        end
        step(1);
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0007) begin
            errors++;
            $display("[TB] FAIL status_busy_illegal got=%h/%0d exp=00000007/4", w, got);
        end
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0003 || st_cnt != s0) begin
            errors++;
            $display("[TB] FAIL status_busy_cleared got=%h/%0d exp=00000003/0", w, st_cnt - s0);
        end
        core_busy = 1'b0;
    endtask

    task automatic test_start_collision;
        logic [31:0] w;
        int got;
        send_pkt(8'h50, 16'h0000, 32'h0);
        core_done = 1'b1;
        checks++;
        if (start_pulse !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision_pulse got=%b exp=1", start_pulse);
        end
        step(1);
        core_done = 1'b0;
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0002) begin
            errors++;
            $display("[TB] FAIL collision_done_kept got=%h/%0d exp=00000002/4", w, got);
        end
        send_pkt(8'h50, 16'h0000, 32'h0);
        step(1);
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL start_clears_done got=%h/%0d exp=00000000/4", w, got);
        end
    endtask

    task automatic test_illegal_cmd;
        logic [31:0] w;
        int got;
        int sum0 = wr_cnt + rd_cnt + a_cnt + b_cnt + st_cnt;
        int t0 = tx_cyc;
        send_pkt(8'h40, 16'h0008, 32'h0);
        step(3);
        checks++;
        if (wr_cnt + rd_cnt + a_cnt + b_cnt + st_cnt != sum0 || tx_cyc != t0 || err_flags !== 3'b001) begin
            errors++;
            $display("[TB] FAIL illegal_cmd got=%0d/%0d/%b exp=0/0/001",
                     wr_cnt + rd_cnt + a_cnt + b_cnt + st_cnt - sum0, tx_cyc - t0, err_flags);
        end
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0004) begin
            errors++;
            $display("[TB] FAIL illegal_cmd_status got=%h/%0d exp=00000004/4", w, got);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] w;
        int got;
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h00);
        step(BYTE_TIMEOUT - 10);
        checks++;
        if (err_flags !== 3'b000) begin
            errors++;
            $display("[TB] FAIL timeout_early got=%b exp=000", err_flags);
        end
        step(20);
        checks++;
        if (err_flags !== 3'b010) begin
            errors++;
            $display("[TB] FAIL timeout_flag got=%b exp=010", err_flags);
        end
        send_pkt(8'h00, 16'h000C, 32'h1234_5678);
        checks++;
        if (csr_wr_en !== 1'b1 || csr_addr !== 8'h0C || csr_wdata !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL timeout_recover got=%b/%h/%h exp=1/0c/12345678", csr_wr_en, csr_addr, csr_wdata);
        end
        step(1);
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0008) begin
            errors++;
            $display("[TB] FAIL timeout_status got=%h/%0d exp=00000008/4", w, got);
        end
    endtask

    task automatic test_csr_rd;
        logic [31:0] w;
        int got;
        csr_rdata = 32'h1234_5678;
        send_pkt(8'h10, 16'h000C, 32'h0);
        checks++;
        if (csr_rd_en !== 1'b1 || csr_addr !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL csr_rd_exec got=%b/%h exp=1/0c", csr_rd_en, csr_addr);
        end
        recv_word(4, 1'b1, 1'b1, w, got);
        checks++;
        if (got != 4 || w !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL csr_rd_data got=%h/%0d exp=12345678/4", w, got);
        end
        checks++;
        if (err_flags !== 3'b100) begin
            errors++;
            $display("[TB] FAIL overrun_flag got=%b exp=100", err_flags);
        end
        step(2);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csr_rd_tx_idle got=%b exp=0", tx_valid);
        end
        send_pkt(8'h10, 16'h0100, 32'h0);
        checks++;
        if (csr_rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csr_rd_bad_strobe got=%b exp=0", csr_rd_en);
        end
        recv_word(4, 1'b1, 1'b0, w, got);
        checks++;
        if (got != 4 || w !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL csr_rd_bad_data got=%h/%0d exp=deadbeef/4", w, got);
        end
        do_status(w, got);
        checks++;
        if (got != 4 || w !== 32'h0000_0014) begin
            errors++;
            $display("[TB] FAIL csr_rd_status got=%h/%0d exp=00000014/4", w, got);
        end
    endtask

    task automatic test_reset_mid_tx;
        send_pkt(8'h70, 16'h0000, 32'h0);
        step(2);
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_tx got=%b exp=1", tx_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || err_flags !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_mid_tx got=%b/%b exp=0/000", tx_valid, err_flags);
        end
        step(1);
        rst_n = 1'b1;
        step(2);
        send_pkt(8'h00, 16'h0033, 32'hA5A5_0001);
        checks++;
        if (csr_wr_en !== 1'b1 || csr_addr !== 8'h33 || csr_wdata !== 32'hA5A5_0001) begin
            errors++;
            $display("[TB] FAIL post_reset_wr got=%b/%h/%h exp=1/33/a5a50001", csr_wr_en, csr_addr, csr_wdata);
        end
        step(2);
    endtask

    initial begin
        $display("[TB] uart_cmd_ctrl directed tests");
        step(2);
        test_reset;
        rst_n = 1'b1;
        step(2);
        test_csr_wr;
        test_buf_wr;
        test_start_done;
        test_start_busy;
        test_start_collision;
        test_illegal_cmd;
        test_timeout;
        test_csr_rd;
        test_reset_mid_tx;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
